// File: rtl/dco_freq_ctrl.sv
// SAR frequency-acquisition controller for a ring-oscillator DCO in the ADPLL loop.
// Optional closed-loop tracking after the search: define DCO_FREQ_CTRL_TRACK_EN.
module dco_freq_ctrl #(
    parameter int unsigned CTRL_WIDTH    = 5,
    parameter int unsigned CNT_W         = 12,
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned TOL           = 2,
    parameter int unsigned LOCK_COUNT    = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic                  stop_i,
    input  logic [CNT_W-1:0]      target_i,
    input  logic [CNT_W-1:0]      dco_count_i,
    input  logic                  count_valid_i,
    output logic                  enable_o,
    output logic [CTRL_WIDTH-1:0] freq_sel_o,
    output logic                  busy_o,
    output logic                  locked_o
);

    localparam int unsigned PtrW = (CTRL_WIDTH > 1) ? $clog2(CTRL_WIDTH) : 1;
    localparam int unsigned SetW = $clog2(SETTLE_CYCLES + 1);

    localparam logic [PtrW-1:0]       PtrMsb     = PtrW'(CTRL_WIDTH - 1);
    localparam logic [SetW-1:0]       SettleLast = SetW'(SETTLE_CYCLES - 1);
    localparam logic [CTRL_WIDTH-1:0] CodeMsb    = CTRL_WIDTH'(1) << (CTRL_WIDTH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSettle,
        StMeasure,
        StDecide,
        StTrackSettle,
        StTrackMeasure,
        StDone
    } state_e;

    state_e                r_state;
    state_e                w_state_next;
    logic [CTRL_WIDTH-1:0] r_code;
    logic [CNT_W-1:0]      r_target;
    logic [CNT_W-1:0]      r_count;
    logic [PtrW-1:0]       r_bit;
    logic [SetW-1:0]       r_settle_cnt;

    logic                  w_in_settle;
    logic                  w_settle_done;
    logic                  w_over;
    logic [CTRL_WIDTH-1:0] w_bit_mask;
    logic [CTRL_WIDTH-1:0] w_decide_code;

    assign w_in_settle   = (r_state == StSettle) || (r_state == StTrackSettle);
    assign w_settle_done = (r_settle_cnt == SettleLast);
    assign w_over        = (r_count > r_target);
    assign w_bit_mask    = CTRL_WIDTH'(1) << r_bit;

    // Resolve the bit under test, then trial-set the next lower one.
    always_comb begin
        w_decide_code = r_code;
        if (w_over) begin
            w_decide_code = w_decide_code & ~w_bit_mask;
        end
        if (r_bit != '0) begin
            w_decide_code = w_decide_code | (w_bit_mask >> 1);
        end
    end

`ifdef DCO_FREQ_CTRL_TRACK_EN
    localparam int unsigned RunW = $clog2(LOCK_COUNT + 1);

    localparam logic [RunW-1:0]  RunMax = RunW'(LOCK_COUNT);
    localparam logic [CNT_W:0]   TolExt = (CNT_W + 1)'(TOL);
    localparam logic [CNT_W:0]   CntMax = {1'b0, {CNT_W{1'b1}}};

    logic [RunW-1:0]       r_run;
    logic                  r_locked;
    logic [CNT_W:0]        w_tgt_ext;
    logic [CNT_W:0]        w_cnt_ext;
    logic [CNT_W:0]        w_hi_raw;
    logic [CNT_W:0]        w_lo;
    logic [CNT_W:0]        w_hi;
    logic                  w_above;
    logic                  w_below;
    logic [RunW-1:0]       w_run_inc;
    logic [CTRL_WIDTH-1:0] w_code_dn;
    logic [CTRL_WIDTH-1:0] w_code_up;

    assign w_tgt_ext = {1'b0, r_target};
    assign w_cnt_ext = {1'b0, dco_count_i};
    assign w_hi_raw  = w_tgt_ext + TolExt;
    assign w_lo      = (w_tgt_ext >= TolExt) ? (w_tgt_ext - TolExt) : '0;
    assign w_hi      = (w_hi_raw > CntMax) ? CntMax : w_hi_raw;
    assign w_above   = (w_cnt_ext > w_hi);
    assign w_below   = (w_cnt_ext < w_lo);
    assign w_run_inc = (r_run == RunMax) ? r_run : (r_run + RunW'(1));
    assign w_code_dn = (r_code == '0) ? r_code : (r_code - CTRL_WIDTH'(1));
    assign w_code_up = (r_code == '1) ? r_code : (r_code + CTRL_WIDTH'(1));
`endif

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (stop_i) begin
            w_state_next = StIdle;
        end else begin
            unique case (r_state)
                StIdle:         if (start_i) w_state_next = StSettle;
                StSettle:       if (w_settle_done) w_state_next = StMeasure;
                StMeasure:      if (count_valid_i) w_state_next = StDecide;
                StDecide: begin
                    if (r_bit != '0) begin
                        w_state_next = StSettle;
                    end else begin
`ifdef DCO_FREQ_CTRL_TRACK_EN
                        w_state_next = StTrackSettle;
`else
                        w_state_next = StDone;
`endif
                    end
                end
                StTrackSettle:  if (w_settle_done) w_state_next = StTrackMeasure;
                StTrackMeasure: if (count_valid_i) w_state_next = StTrackSettle;
                StDone:         w_state_next = StDone;
                default:        w_state_next = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_code       <= '0;
            r_target     <= '0;
            r_count      <= '0;
            r_bit        <= '0;
            r_settle_cnt <= '0;
`ifdef DCO_FREQ_CTRL_TRACK_EN
            r_run        <= '0;
            r_locked     <= 1'b0;
`endif
        end else begin
            r_settle_cnt <= (w_in_settle && !w_settle_done) ? (r_settle_cnt + SetW'(1)) : '0;
            if (stop_i) begin
`ifdef DCO_FREQ_CTRL_TRACK_EN
                r_locked <= 1'b0;
`endif
            end else begin
                case (r_state)
                    StIdle: begin
                        if (start_i) begin
                            r_target <= target_i;
                            r_code   <= CodeMsb;
                            r_bit    <= PtrMsb;
                        end
                    end
                    StMeasure: begin
                        if (count_valid_i) begin
                            r_count <= dco_count_i;
                        end
                    end
                    StDecide: begin
                        r_code <= w_decide_code;
                        if (r_bit != '0) begin
                            r_bit <= r_bit - PtrW'(1);
                        end
`ifdef DCO_FREQ_CTRL_TRACK_EN
                        r_run    <= '0;
                        r_locked <= 1'b0;
`endif
                    end
`ifdef DCO_FREQ_CTRL_TRACK_EN
                    StTrackMeasure: begin
                        if (count_valid_i) begin
                            if (w_above) begin
                                r_code   <= w_code_dn;
                                r_run    <= '0;
                                r_locked <= 1'b0;
                            end else if (w_below) begin
                                r_code   <= w_code_up;
                                r_run    <= '0;
                                r_locked <= 1'b0;
                            end else begin
                                r_run    <= w_run_inc;
                                r_locked <= (w_run_inc >= RunMax);
                            end
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        busy_o     = (r_state != StIdle);
        enable_o   = (r_state != StIdle);
        freq_sel_o = r_code;
`ifdef DCO_FREQ_CTRL_TRACK_EN
        locked_o   = r_locked;
`else
        locked_o   = (r_state == StDone);
`endif
    end

endmodule
